// File: rtl/branch_resolve_unit.sv
// Branch resolution unit for the RV32 multi-cycle datapath: evaluates B-type
// conditions, drives pc_src, and keeps a 2-bit predictor table plus statistics.
module branch_resolve_unit #(
    parameter int XLEN      = 32,
    parameter int PHT_DEPTH = 16,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             br_valid,
    input  logic [2:0]       func3,
    input  logic [XLEN-1:0]  rs1,
    input  logic [XLEN-1:0]  rs2,
    input  logic [XLEN-1:0]  pc,
    input  logic [XLEN-1:0]  query_pc,
    input  logic             stat_clr,
    output logic             busy,
    output logic             br_done,
    output logic [1:0]       pc_src,
    output logic             mispredict,
    output logic             illegal,
    output logic             pred_taken,
    output logic [CNT_W-1:0] taken_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam int IDX_W = $clog2(PHT_DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    logic [2:0]       cap_func3;
    logic [XLEN-1:0]  cap_rs1;
    logic [XLEN-1:0]  cap_rs2;
    logic [IDX_W-1:0] cap_idx;
    logic             cap_pred;
    logic [1:0]       pht [PHT_DEPTH];

    logic eval_taken;
    logic eval_legal;
    logic eval_mispred;
    logic eval_commit;
    logic unused_bits;

    assign busy       = (state != IDLE);
    assign pred_taken = pht[query_pc[IDX_W+1:2]][1];
    assign unused_bits = ^{pc[XLEN-1:IDX_W+2], pc[1:0],
                           query_pc[XLEN-1:IDX_W+2], query_pc[1:0]};

    // Branch condition from the operands latched at capture time.
    always_comb begin
        eval_taken = 1'b0;
        eval_legal = 1'b1;
        case (cap_func3)
            3'b000:  eval_taken = (cap_rs1 == cap_rs2);
            3'b001:  eval_taken = (cap_rs1 != cap_rs2);
            3'b100:  eval_taken = ($signed(cap_rs1) < $signed(cap_rs2));
            3'b101:  eval_taken = ($signed(cap_rs1) >= $signed(cap_rs2));
            3'b110:  eval_taken = (cap_rs1 < cap_rs2);
            3'b111:  eval_taken = (cap_rs1 >= cap_rs2);
            default: eval_legal = 1'b0;
        endcase
        eval_mispred = eval_legal && (cap_pred != eval_taken);
        eval_commit  = (state == EVAL) && eval_legal;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cap_func3  <= 3'b000;
            cap_rs1    <= '0;
            cap_rs2    <= '0;
            cap_idx    <= '0;
            cap_pred   <= 1'b0;
            br_done    <= 1'b0;
            pc_src     <= 2'b00;
            mispredict <= 1'b0;
            illegal    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    br_done <= 1'b0;
                    if (br_valid) begin
                        cap_func3 <= func3;
                        cap_rs1   <= rs1;
                        cap_rs2   <= rs2;
                        cap_idx   <= pc[IDX_W+1:2];
                        cap_pred  <= pht[pc[IDX_W+1:2]][1];
                        state     <= EVAL;
                    end
                end
                EVAL: begin
                    br_done    <= 1'b1;
                    pc_src     <= {1'b0, eval_taken};
                    mispredict <= eval_mispred;
                    illegal    <= !eval_legal;
                    state      <= RESP;
                end
                RESP: begin
                    br_done <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    br_done <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    // Predictor table: each entry saturates in the direction of the outcome.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PHT_DEPTH; i++) begin
                pht[i] <= 2'b01;
            end
        end else if (eval_commit) begin
            if (eval_taken) begin
                if (pht[cap_idx] != 2'b11) pht[cap_idx] <= pht[cap_idx] + 2'd1;
            end else begin
                if (pht[cap_idx] != 2'b00) pht[cap_idx] <= pht[cap_idx] - 2'd1;
            end
        end
    end

    // A clear in the same cycle as an increment wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            taken_cnt   <= '0;
            mispred_cnt <= '0;
        end else if (stat_clr) begin
            taken_cnt   <= '0;
            mispred_cnt <= '0;
        end else if (eval_commit) begin
            if (eval_taken && (taken_cnt != '1))
                taken_cnt <= taken_cnt + CNT_W'(1);
            if (eval_mispred && (mispred_cnt != '1))
                mispred_cnt <= mispred_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed self-checking bench for branch_resolve_unit: condition codes,
// predictor training, illegal codes, busy-time requests, stat clear and reset.
module tb_branch_resolve_unit;

    logic        clk;
    logic        rst;
    logic        br_valid;
    logic [2:0]  func3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] pc;
    logic [31:0] query_pc;
    logic        stat_clr;
    logic        busy;
    logic        br_done;
    logic [1:0]  pc_src;
    logic        mispredict;
    logic        illegal;
    logic        pred_taken;
    logic [15:0] taken_cnt;
    logic [15:0] mispred_cnt;

    int tests_run;
    int tests_failed;

    branch_resolve_unit dut (
        .clk         (clk),
        .rst         (rst),
        .br_valid    (br_valid),
        .func3       (func3),
        .rs1         (rs1),
        .rs2         (rs2),
        .pc          (pc),
        .query_pc    (query_pc),
        .stat_clr    (stat_clr),
        .busy        (busy),
        .br_done     (br_done),
        .pc_src      (pc_src),
        .mispredict  (mispredict),
        .illegal     (illegal),
        .pred_taken  (pred_taken),
        .taken_cnt   (taken_cnt),
        .mispred_cnt (mispred_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Drives a request, lets it be captured, and returns at the EVAL-cycle negedge.
    task automatic apply_stimulus(input logic [2:0] f, input logic [31:0] a,
                                  input logic [31:0] b, input logic [31:0] p);
        @(negedge clk);
        br_valid = 1'b1;
        func3    = f;
        rs1      = a;
        rs2      = b;
        pc       = p;
        @(posedge clk);
        @(negedge clk);
        br_valid = 1'b0;
    endtask

    task automatic to_resp;
        @(negedge clk);
    endtask

    task automatic check_result(input string tag, input logic [1:0] exp_src,
                                input logic exp_mis, input logic exp_ill,
                                input logic [15:0] exp_tc, input logic [15:0] exp_mc);
        check_output({tag, ".br_done"}, {31'd0, br_done}, 32'd1);
        check_output({tag, ".pc_src"}, {30'd0, pc_src}, {30'd0, exp_src});
        check_output({tag, ".mispredict"}, {31'd0, mispredict}, {31'd0, exp_mis});
        check_output({tag, ".illegal"}, {31'd0, illegal}, {31'd0, exp_ill});
        check_output({tag, ".taken_cnt"}, {16'd0, taken_cnt}, {16'd0, exp_tc});
        check_output({tag, ".mispred_cnt"}, {16'd0, mispred_cnt}, {16'd0, exp_mc});
    endtask

    task automatic check_pred(input string tag, input logic [31:0] qpc, input logic exp);
        query_pc = qpc;
        #1;
        check_output(tag, {31'd0, pred_taken}, {31'd0, exp});
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst      = 1'b1;
        br_valid = 1'b0;
        func3    = 3'b000;
        rs1      = '0;
        rs2      = '0;
        pc       = '0;
        query_pc = '0;
        stat_clr = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;

        check_output("reset.busy", {31'd0, busy}, 32'd0);
        check_output("reset.br_done", {31'd0, br_done}, 32'd0);
        check_output("reset.pc_src", {30'd0, pc_src}, 32'd0);
        check_output("reset.mispredict", {31'd0, mispredict}, 32'd0);
        check_output("reset.illegal", {31'd0, illegal}, 32'd0);
        check_output("reset.taken_cnt", {16'd0, taken_cnt}, 32'd0);
        check_output("reset.mispred_cnt", {16'd0, mispred_cnt}, 32'd0);
        check_pred("reset.pred40", 32'h40, 1'b0);

        // BEQ equal, idx1: result appears two cycles after the capture cycle
        apply_stimulus(3'b000, 32'h1234, 32'h1234, 32'h104);
        check_output("beq.eval_busy", {31'd0, busy}, 32'd1);
        check_output("beq.eval_done", {31'd0, br_done}, 32'd0);
        to_resp();
        check_output("beq.resp_busy", {31'd0, busy}, 32'd1);
        check_result("beq", 2'b01, 1'b1, 1'b0, 16'd1, 16'd1);
        @(negedge clk);
        check_output("beq.after_done", {31'd0, br_done}, 32'd0);
        check_output("beq.after_busy", {31'd0, busy}, 32'd0);
        check_output("beq.hold_src", {30'd0, pc_src}, 32'd1);
        check_pred("beq.pred104", 32'h104, 1'b1);

        // Signed vs unsigned less-than on the same operands
        apply_stimulus(3'b100, 32'hFFFF_FFFB, 32'd3, 32'h108);
        to_resp();
        check_result("blt", 2'b01, 1'b1, 1'b0, 16'd2, 16'd2);
        apply_stimulus(3'b110, 32'hFFFF_FFFB, 32'd3, 32'h10C);
        to_resp();
        check_result("bltu", 2'b00, 1'b0, 1'b0, 16'd2, 16'd2);
        apply_stimulus(3'b101, 32'd7, 32'd7, 32'h110);
        to_resp();
        check_result("bge", 2'b01, 1'b1, 1'b0, 16'd3, 16'd3);
        apply_stimulus(3'b111, 32'd7, 32'd7, 32'h114);
        to_resp();
        check_result("bgeu", 2'b01, 1'b1, 1'b0, 16'd4, 16'd4);
        apply_stimulus(3'b001, 32'd7, 32'd7, 32'h118);
        to_resp();
        check_result("bne", 2'b00, 1'b0, 1'b0, 16'd4, 16'd4);

        // Train PHT[0] with four taken branches at 0x40: 01->10->11->11
        apply_stimulus(3'b000, 32'd5, 32'd5, 32'h40);
        check_pred("train1.eval_pred", 32'h40, 1'b0);
        to_resp();
        check_result("train1", 2'b01, 1'b1, 1'b0, 16'd5, 16'd5);
        check_pred("train1.pred", 32'h40, 1'b1);
        apply_stimulus(3'b000, 32'd5, 32'd5, 32'h40);
        to_resp();
        check_result("train2", 2'b01, 1'b0, 1'b0, 16'd6, 16'd5);
        apply_stimulus(3'b000, 32'd5, 32'd5, 32'h40);
        to_resp();
        check_result("train3", 2'b01, 1'b0, 1'b0, 16'd7, 16'd5);
        apply_stimulus(3'b000, 32'd5, 32'd5, 32'h40);
        to_resp();
        check_result("train4", 2'b01, 1'b0, 1'b0, 16'd8, 16'd5);
        check_pred("train4.pred", 32'h40, 1'b1);
        // Not taken from a saturated 11 lands on 10: still predicts taken
        apply_stimulus(3'b001, 32'd5, 32'd5, 32'h40);
        to_resp();
        check_result("untrain", 2'b00, 1'b1, 1'b0, 16'd8, 16'd6);
        check_pred("untrain.pred", 32'h40, 1'b1);

        // Illegal code at idx1 (entry 10): a not-taken update would clear the MSB
        apply_stimulus(3'b010, 32'd1, 32'd2, 32'h104);
        to_resp();
        check_result("ill010", 2'b00, 1'b0, 1'b1, 16'd8, 16'd6);
        check_pred("ill010.pred104", 32'h104, 1'b1);
        apply_stimulus(3'b011, 32'd9, 32'd9, 32'h104);
        to_resp();
        check_result("ill011", 2'b00, 1'b0, 1'b1, 16'd8, 16'd6);
        check_pred("ill011.pred104", 32'h104, 1'b1);

        // Request raised during EVAL must be dropped
        apply_stimulus(3'b000, 32'd3, 32'd3, 32'h11C);
        br_valid = 1'b1;
        func3    = 3'b000;
        rs1      = 32'd1;
        rs2      = 32'd1;
        pc       = 32'h120;
        to_resp();
        br_valid = 1'b0;
        check_result("busyreq", 2'b01, 1'b1, 1'b0, 16'd9, 16'd7);
        @(negedge clk);
        check_output("busyreq.idle", {31'd0, busy}, 32'd0);
        check_pred("busyreq.pred120", 32'h120, 1'b0);
        check_pred("busyreq.pred11c", 32'h11C, 1'b1);

        // Clear coinciding with an increment wins
        apply_stimulus(3'b000, 32'd3, 32'd3, 32'h124);
        stat_clr = 1'b1;
        to_resp();
        stat_clr = 1'b0;
        check_result("statclr", 2'b01, 1'b1, 1'b0, 16'd0, 16'd0);

        // Reset during EVAL aborts the pending update
        apply_stimulus(3'b000, 32'd3, 32'd3, 32'h128);
        to_resp();
        check_result("prerst", 2'b01, 1'b1, 1'b0, 16'd1, 16'd1);
        apply_stimulus(3'b000, 32'd3, 32'd3, 32'h12C);
        #1 rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        check_output("rst.busy", {31'd0, busy}, 32'd0);
        check_output("rst.br_done", {31'd0, br_done}, 32'd0);
        check_output("rst.pc_src", {30'd0, pc_src}, 32'd0);
        check_output("rst.mispredict", {31'd0, mispredict}, 32'd0);
        check_output("rst.taken_cnt", {16'd0, taken_cnt}, 32'd0);
        check_output("rst.mispred_cnt", {16'd0, mispred_cnt}, 32'd0);
        check_pred("rst.pred40", 32'h40, 1'b0);
        check_pred("rst.pred104", 32'h104, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check_output("rst.late_done", {31'd0, br_done}, 32'd0);
        check_output("rst.late_cnt", {16'd0, taken_cnt}, 32'd0);
        check_pred("rst.pred12c", 32'h12C, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
